// File: rtl/jump_input_ctrl.sv
// Jump button front end: sync, debounce, press edge, jump request latch.
// Ports: CLK100MHZ, reset_btn (async high), jump_btn (raw), game_tick,
//   isdead in; press, btn_level, jump_req, start, state[1:0] out.
module jump_input_ctrl #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int CNT_W           = 20
) (
  input  logic       CLK100MHZ,
  input  logic       reset_btn,
  input  logic       jump_btn,
  input  logic       game_tick,
  input  logic       isdead,
  output logic       press,
  output logic       btn_level,
  output logic       jump_req,
  output logic       start,
  output logic [1:0] state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DEAD = 2'd2
  } st_e;

  localparam logic [CNT_W-1:0] CNT_MAX =
    CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync;
  logic [CNT_W-1:0]       cnt;
  logic                   s;
  st_e                    st;
  st_e                    st_nx;
  logic                   jr_nx;

  assign s     = sync[SYNC_STAGES-1];
  assign state = st;

  always_ff @(posedge CLK100MHZ or posedge reset_btn) begin
    if (reset_btn) begin
      sync      <= '0;
      cnt       <= '0;
      btn_level <= 1'b0;
      press     <= 1'b0;
    end else begin
      sync  <= {sync[SYNC_STAGES-2:0], jump_btn};
      press <= 1'b0;
      if (s == btn_level) begin
        cnt <= '0;
      end else if (cnt == CNT_MAX) begin
        // Level accepted; pulse only on the rising acceptance.
        btn_level <= s;
        press     <= s;
        cnt       <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  always_comb begin
    st_nx = IDLE;
    unique case (st)
      IDLE:    st_nx = press  ? RUN  : IDLE;
      RUN:     st_nx = isdead ? DEAD : RUN;
      DEAD:    st_nx = press  ? IDLE : DEAD;
      default: st_nx = IDLE;
    endcase
  end

  // A press in RUN beats a same-cycle tick so it is never lost.
  always_comb begin
    jr_nx = jump_req;
    if (st != RUN || st_nx != RUN) begin
      jr_nx = 1'b0;
    end else if (press) begin
      jr_nx = 1'b1;
    end else if (game_tick) begin
      jr_nx = 1'b0;
    end
  end

  always_ff @(posedge CLK100MHZ or posedge reset_btn) begin
    if (reset_btn) begin
      st       <= IDLE;
      start    <= 1'b0;
      jump_req <= 1'b0;
    end else begin
      st       <= st_nx;
      start    <= (st_nx == RUN);
      jump_req <= jr_nx;
    end
  end

endmodule

// File: tb/tb_jump_input_ctrl.sv
// Directed bench for jump_input_ctrl (SYNC_STAGES=2, DEBOUNCE_CYCLES=4).
// Inputs change 1 time unit after a rising edge; outputs sampled there too.
module tb_jump_input_ctrl;

  logic       CLK100MHZ = 1'b0;
  logic       reset_btn;
  logic       jump_btn;
  logic       game_tick;
  logic       isdead;
  logic       press;
  logic       btn_level;
  logic       jump_req;
  logic       start;
  logic [1:0] state;

  int n_assert = 0;
  int n_fail   = 0;
  int n_press;
  int p_idx;

  jump_input_ctrl #(
    .SYNC_STAGES    (2),
    .DEBOUNCE_CYCLES(4),
    .CNT_W          (3)
  ) dut (
    .CLK100MHZ(CLK100MHZ),
    .reset_btn(reset_btn),
    .jump_btn (jump_btn),
    .game_tick(game_tick),
    .isdead   (isdead),
    .press    (press),
    .btn_level(btn_level),
    .jump_req (jump_req),
    .start    (start),
    .state    (state)
  );

  always #5 CLK100MHZ = ~CLK100MHZ;

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge CLK100MHZ);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_all0(input string tag);
    chk({tag, ".press"}, 32'(press), 0);
    chk({tag, ".level"}, 32'(btn_level), 0);
    chk({tag, ".jreq"}, 32'(jump_req), 0);
    chk({tag, ".start"}, 32'(start), 0);
    chk({tag, ".state"}, 32'(state), 0);
  endtask

  // Release and let the low level be accepted (2 sync + 4 debounce + margin).
  task automatic release_btn();
    jump_btn = 1'b0;
    step(8);
  endtask

  // Raise the button; press is high after the 6th edge.
  task automatic press_btn(input string tag);
    jump_btn = 1'b1;
    step(5);
    chk({tag, ".pre"}, 32'(press), 0);
    step(1);
    chk({tag, ".press"}, 32'(press), 1);
  endtask

  logic [11:0] bounce;

  initial begin
    reset_btn = 1'b0;
    jump_btn  = 1'b0;
    game_tick = 1'b0;
    isdead    = 1'b0;
    #1 reset_btn = 1'b1;
    #1 chk_all0("rst_async");

    // Button held through reset.
    jump_btn = 1'b1;
    step(3);
    chk_all0("rst_hold");
    reset_btn = 1'b0;
    step(5);
    chk("rst_rel.press_early", 32'(press), 0);
    step(1);
    chk("rst_rel.press", 32'(press), 1);
    chk("rst_rel.level", 32'(btn_level), 1);
    chk("rst_rel.state0", 32'(state), 0);
    step(1);
    chk("rst_rel.press_once", 32'(press), 0);
    chk("rst_rel.state1", 32'(state), 1);
    chk("rst_rel.start", 32'(start), 1);
    chk("rst_rel.no_jreq", 32'(jump_req), 0);

    release_btn();
    chk("release.level", 32'(btn_level), 0);
    chk("release.no_press", 32'(press), 0);

    // Bounce: 1x3, 0x1, 1x3, then 0 (LSB first).
    bounce = 12'b0000_0111_0111;
    for (int i = 0; i < 12; i++) begin
      jump_btn = bounce[i];
      step(1);
      chk("bounce.level", 32'(btn_level), 0);
      chk("bounce.press", 32'(press), 0);
    end

    // Held 10 cycles: one press at the 6th edge, jump_req one edge later.
    n_press = 0;
    p_idx   = -1;
    jump_btn = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step(1);
      if (press) begin
        n_press++;
        p_idx = i;
      end
      if (i == 5) chk("hs.jreq_pre", 32'(jump_req), 0);
      if (i == 6) chk("hs.jreq_set", 32'(jump_req), 1);
    end
    chk("hs.n_press", 32'(n_press), 1);
    chk("hs.p_idx", 32'(p_idx), 5);
    step(20);
    chk("hs.jreq_hold", 32'(jump_req), 1);
    game_tick = 1'b1;
    step(1);
    game_tick = 1'b0;
    chk("hs.jreq_consumed", 32'(jump_req), 0);
    n_press = 0;
    for (int i = 0; i < 10; i++) begin
      step(1);
      if (press) n_press++;
    end
    chk("hs.no_repress", 32'(n_press), 0);
    chk("hs.no_rereq", 32'(jump_req), 0);

    // Collision: press and tick in the same cycle.
    release_btn();
    press_btn("col");
    game_tick = 1'b1;
    step(1);
    game_tick = 1'b0;
    chk("col.jreq_kept", 32'(jump_req), 1);
    game_tick = 1'b1;
    step(1);
    game_tick = 1'b0;
    chk("col.jreq_cleared", 32'(jump_req), 0);

    // Death with a pending request and a simultaneous press.
    release_btn();
    press_btn("dth_a");
    step(1);
    chk("dth.jreq_set", 32'(jump_req), 1);
    release_btn();
    chk("dth.jreq_held", 32'(jump_req), 1);
    press_btn("dth_b");
    isdead = 1'b1;
    step(1);
    chk("dth.state", 32'(state), 2);
    chk("dth.start", 32'(start), 0);
    chk("dth.jreq", 32'(jump_req), 0);
    release_btn();
    chk("dth.stay", 32'(state), 2);
    press_btn("dth_c");
    step(1);
    chk("dth.idle", 32'(state), 0);
    isdead = 1'b0;
    release_btn();
    press_btn("dth_d");
    step(1);
    chk("dth.run", 32'(state), 1);
    chk("dth.run_start", 32'(start), 1);
    chk("dth.run_jreq", 32'(jump_req), 0);

    // Mid-debounce reset: counter at 2 on a release.
    jump_btn = 1'b0;
    step(4);
    chk("mid.level_pre", 32'(btn_level), 1);
    #1 reset_btn = 1'b1;
    #1 chk_all0("mid_rst");
    jump_btn = 1'b1;
    step(2);
    chk_all0("mid_hold");
    reset_btn = 1'b0;
    step(5);
    chk("mid.press_early", 32'(press), 0);
    step(1);
    chk("mid.press", 32'(press), 1);
    step(1);
    chk("mid.state", 32'(state), 1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
